uart_gesture_rx: RTL and testbench
==================================

Name: uart_gesture_rx

Overview:
Receives gesture codes from the host classifier over a UART line (8N1, LSB first) and presents a stable 8-bit gesture code to the downstream gesture decoder. A byte is forwarded only after it has arrived CONFIRM times in a row and lies in the valid code range. This suppresses classifier jitter and line noise before the servo stage. The gesture output holds its last confirmed value indefinitely.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate
CONFIRM, 2, consecutive identical valid bytes required before forwarding (1..15)
MAX_CODE, 11, highest valid gesture code; valid range is 1..MAX_CODE

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-low
rx  input  1  UART serial input, asynchronous to clk, idles high
gesture  output  8  confirmed gesture code, drives the gesture decoder's gesture input
gesture_valid  output  1  one-cycle pulse on every write of gesture
frame_err  output  1  one-cycle pulse when a stop bit is sampled low

Behaviour:
- CPB = CLK_HZ/BAUD, integer division. HALF = CPB/2. The bit counter is wide enough for CPB-1.
- rx passes through a 2-flop synchronizer whose flops reset to 1. Here rx_s means the synchronizer output.
- Reset values: gesture=0, gesture_valid=0, frame_err=0, FSM=IDLE, last_byte=0, match_cnt=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte has any effect.
- FSM states:
  - IDLE: when rx_s=0, load the counter and go to START.
  - START: after HALF clocks, sample rx_s. If 0, go to DATA with bit index 0. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: every CPB clocks, sample rx_s into bit[index], LSB first. After bit 7 is sampled, go to STOP.
  - STOP: after CPB clocks, sample rx_s. If 1, the byte is accepted and the FSM goes to IDLE. If 0, pulse frame_err, discard the byte and go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s=1, then go to IDLE. A held-low break line therefore yields exactly one frame_err.
- Match/confirm logic, evaluated on an accepted byte b:
  - If b=0 or b>MAX_CODE: last_byte<=0 and match_cnt<=0. gesture is unchanged.
  - Else if b==last_byte: match_cnt<=min(match_cnt+1, CONFIRM).
  - Else: last_byte<=b and match_cnt<=1.
  - If the updated match_cnt is >= CONFIRM: gesture<=b and gesture_valid pulses. This repeats on every further identical byte while the count stays saturated.
  - A frame error does not alter last_byte or match_cnt.
- Latency: gesture and gesture_valid update on the clock edge after the stop-bit sample cycle. frame_err asserts on the clock edge after the stop-bit sample cycle.
- gesture never takes the value 0 after reset. 0 and out-of-range codes are never forwarded.
- gesture_valid and frame_err are never high in the same cycle.

Test Plan:
(Bench parameters: CLK_HZ=1000000, BAUD=100000 so CPB=10; CONFIRM=2; MAX_CODE=11.)
1. Reset low for 5 clocks, rx=1, then release → gesture=0x00, gesture_valid=0, frame_err=0. No activity for 200 clocks.
2. Send 0x03 then 0x03 → no pulse after the first byte. After the second stop bit, gesture=0x03 and gesture_valid is high for exactly 1 cycle. A third 0x03 gives another 1-cycle pulse with gesture still 0x03.
3. Send 0x03, 0x05, 0x05 with gesture at 0x03 → gesture stays 0x03 through the first 0x05 and becomes 0x05 after the second 0x05.
4. Send 0x0C, 0x0C, then 0x00, 0x00 → gesture unchanged and no gesture_valid. Then 0x07, 0x0C, 0x07 → no update, because the out-of-range byte breaks the streak.
5. Send 0x04 with stop bit=0, then hold rx low for 30 clocks → exactly one frame_err pulse and no gesture change. Then 0x04, 0x04 → gesture=0x04.
6. Drive a 3-clock low glitch on rx → returns to IDLE with no output. Assert reset during bit 4 of a 0x02 frame while gesture=0x05 → gesture=0x00. After release, 0x02, 0x02 → gesture=0x02.

Source files
------------

// File: rtl/uart_gesture_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_gesture_rx
// Purpose  : 8N1 UART receiver (LSB first) for classifier gesture codes.
//            A byte is forwarded to the gesture decoder only after it has
//            arrived CONFIRM times in a row and lies in 1..MAX_CODE. The
//            forwarded code is held until the next confirmed write.
// Ports    : clk           - system clock
//            reset         - asynchronous, active-low reset
//            rx            - UART serial input (asynchronous, idles high)
//            gesture       - confirmed gesture code (8 bits)
//            gesture_valid - one-cycle pulse on every write of gesture
//            frame_err     - one-cycle pulse when a stop bit is sampled low
// Revision : 1.0 - initial release
// ============================================================================
module uart_gesture_rx #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 115200,
  parameter int CONFIRM  = 2,
  parameter int MAX_CODE = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] gesture,
  output logic       gesture_valid,
  output logic       frame_err
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [3:0]       CONF_C  = 4'(CONFIRM);
  localparam logic [7:0]       MAX_C   = 8'(MAX_CODE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       last_byte_q, last_byte_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       gesture_q, gesture_d;
  logic             gesture_valid_q, gesture_valid_d;
  logic             frame_err_q, frame_err_d;

  // Confirmation bookkeeping for the byte currently held in the shift
  // register; only committed when the stop bit is sampled high.
  logic       byte_ok;
  logic [3:0] match_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      last_byte_q     <= '0;
      match_cnt_q     <= '0;
      gesture_q       <= '0;
      gesture_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      rx_meta_q       <= rx;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      last_byte_q     <= last_byte_d;
      match_cnt_q     <= match_cnt_d;
      gesture_q       <= gesture_d;
      gesture_valid_q <= gesture_valid_d;
      frame_err_q     <= frame_err_d;
    end
  end

  always_comb begin
    byte_ok    = (shift_q != 8'd0) && (shift_q <= MAX_C);
    match_next = 4'd0;
    if (byte_ok) begin
      if (shift_q == last_byte_q) begin
        // Saturate at CONFIRM so a long run keeps re-confirming.
        match_next = (match_cnt_q >= CONF_C) ? CONF_C : match_cnt_q + 4'd1;
      end else begin
        match_next = 4'd1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    last_byte_d     = last_byte_q;
    match_cnt_d     = match_cnt_q;
    gesture_d       = gesture_q;
    gesture_valid_d = 1'b0;
    frame_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_M1;
          state_d = START;
        end
      end

      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s_q) begin
          // Start bit gone by mid-bit: line glitch, not a frame.
          state_d = IDLE;
        end else begin
          cnt_d     = CPB_M1;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d[bit_idx_q] = rx_s_q;
          cnt_d              = CPB_M1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s_q) begin
          state_d     = IDLE;
          last_byte_d = byte_ok ? shift_q : 8'd0;
          match_cnt_d = match_next;
          if (byte_ok && (match_next >= CONF_C)) begin
            gesture_d       = shift_q;
            gesture_valid_d = 1'b1;
          end
        end else begin
          // Bad stop bit: drop the byte and wait out any break condition
          // so a held-low line reports only one error.
          frame_err_d = 1'b1;
          state_d     = BRK_WAIT;
        end
      end

      BRK_WAIT: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gesture       = gesture_q;
  assign gesture_valid = gesture_valid_q;
  assign frame_err     = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_gesture_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_gesture_rx
// Purpose  : Self-checking bench for uart_gesture_rx. A frame-level model of
//            the confirm rules predicts every gesture_valid / frame_err
//            pulse; a per-cycle monitor checks the DUT against it, and
//            literal checkpoints pin the model's results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_gesture_rx;

  localparam int CPB      = 10;
  localparam int CONFIRM  = 2;
  localparam int MAX_CODE = 11;
  localparam int FERR_EV  = 256;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] gesture;
  logic       gesture_valid;
  logic       frame_err;

  uart_gesture_rx #(
    .CLK_HZ  (1000000),
    .BAUD    (100000),
    .CONFIRM (CONFIRM),
    .MAX_CODE(MAX_CODE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .gesture      (gesture),
    .gesture_valid(gesture_valid),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int exp_q[$];    // expected pulse events: byte code, or FERR_EV
  int m_gesture;   // gesture value the DUT must be holding
  int m_last;
  int m_cnt;
  int n_valid;     // observed gesture_valid pulses
  int n_ferr;      // observed frame_err pulses

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level confirm rule for an accepted byte.
  task automatic model_accept(input int b);
    if (b == 0 || b > MAX_CODE) begin
      m_last = 0;
      m_cnt  = 0;
    end else begin
      if (b == m_last) m_cnt = (m_cnt + 1 > CONFIRM) ? CONFIRM : m_cnt + 1;
      else begin
        m_last = b;
        m_cnt  = 1;
      end
      if (m_cnt >= CONFIRM) exp_q.push_back(b);
    end
  endtask

  // Monitor: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      m_gesture = 0;
      exp_q.delete();
    end else begin
      check(!(gesture_valid && frame_err), "valid_and_ferr_together",
            int'({gesture_valid, frame_err}), 0);
      if (gesture_valid) begin
        if (exp_q.size() == 0 || exp_q[0] == FERR_EV) begin
          check(1'b0, "unexpected_gesture_valid", int'(gesture), -1);
        end else begin
          check(int'(gesture) == exp_q[0], "gesture_on_valid", int'(gesture), exp_q[0]);
          m_gesture = exp_q[0];
          void'(exp_q.pop_front());
        end
        n_valid++;
      end else if (frame_err) begin
        if (exp_q.size() == 0 || exp_q[0] != FERR_EV) begin
          check(1'b0, "unexpected_frame_err", 1, 0);
        end else begin
          void'(exp_q.pop_front());
        end
        n_ferr++;
      end
      check(int'(gesture) == m_gesture, "gesture_hold", int'(gesture), m_gesture);
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    clocks(CPB);
  endtask

  // Full frame; stop_ok=0 sends a low stop bit and holds the line low
  // for 30 more clocks (break).
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_ok) begin
      model_accept(int'(b));
      drive_bit(1'b1);
    end else begin
      exp_q.push_back(FERR_EV);
      drive_bit(1'b0);
      clocks(30);
      rx = 1'b1;
    end
    clocks(2 * CPB);
    check(exp_q.size() == 0, "pending_event", exp_q.size(), 0);
  endtask

  int v0, f0;

  initial begin
    m_gesture = 0; m_last = 0; m_cnt = 0; n_valid = 0; n_ferr = 0;
    reset = 1'b0;
    rx    = 1'b1;
    clocks(5);
    reset = 1'b1;
    clocks(1);

    // 1: reset state and quiet line
    check(gesture == 8'h00, "reset_gesture", int'(gesture), 0);
    check(gesture_valid == 1'b0, "reset_valid", int'(gesture_valid), 0);
    check(frame_err == 1'b0, "reset_ferr", int'(frame_err), 0);
    clocks(200);
    check(n_valid + n_ferr == 0, "idle_no_pulses", n_valid + n_ferr, 0);

    // 2: confirm after two, re-pulse on the third
    v0 = n_valid;
    send_byte(8'h03, 1'b1);
    check(n_valid - v0 == 0, "t2_first_no_pulse", n_valid - v0, 0);
    send_byte(8'h03, 1'b1);
    check(gesture == 8'h03, "t2_gesture", int'(gesture), 3);
    check(n_valid - v0 == 1, "t2_one_pulse", n_valid - v0, 1);
    send_byte(8'h03, 1'b1);
    check(n_valid - v0 == 2, "t2_repeat_pulse", n_valid - v0, 2);

    // 3: change of code needs a fresh streak
    send_byte(8'h03, 1'b1);
    send_byte(8'h05, 1'b1);
    check(gesture == 8'h03, "t3_hold_after_first_05", int'(gesture), 3);
    send_byte(8'h05, 1'b1);
    check(gesture == 8'h05, "t3_gesture", int'(gesture), 5);

    // 4: out-of-range and zero codes never forward and break streaks
    v0 = n_valid;
    send_byte(8'h0C, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h07, 1'b1);
    check(n_valid - v0 == 0, "t4_no_pulses", n_valid - v0, 0);
    check(gesture == 8'h05, "t4_gesture", int'(gesture), 5);

    // 5: frame error with break, then recovery
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h04, 1'b0);
    check(n_ferr - f0 == 1, "t5_one_ferr", n_ferr - f0, 1);
    check(n_valid - v0 == 0, "t5_no_valid", n_valid - v0, 0);
    send_byte(8'h04, 1'b1);
    send_byte(8'h04, 1'b1);
    check(gesture == 8'h04, "t5_gesture", int'(gesture), 4);

    // 6: glitch rejection
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    clocks(3);
    rx = 1'b1;
    clocks(40);
    check(n_valid - v0 + n_ferr - f0 == 0, "t6_glitch_silent", n_valid - v0 + n_ferr - f0, 0);
    send_byte(8'h05, 1'b1);
    send_byte(8'h05, 1'b1);
    check(gesture == 8'h05, "t6_pre_reset_gesture", int'(gesture), 5);

    // 6: reset during bit 4 of a 0x02 frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 1);
    clocks(4);
    reset = 1'b0;
    rx    = 1'b1;
    m_last = 0;
    m_cnt  = 0;
    clocks(5);
    check(gesture == 8'h00, "t6_reset_gesture", int'(gesture), 0);
    reset = 1'b1;
    v0 = n_valid; f0 = n_ferr;
    clocks(30);
    check(n_valid - v0 + n_ferr - f0 == 0, "t6_no_partial_effect", n_valid - v0 + n_ferr - f0, 0);
    send_byte(8'h02, 1'b1);
    check(gesture == 8'h00, "t6_after_first_02", int'(gesture), 0);
    send_byte(8'h02, 1'b1);
    check(gesture == 8'h02, "t6_gesture", int'(gesture), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
